// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 encodings of the M-extension operations
//   - opcode/funct7 constants that identify an M instruction
//   - controller state encoding
//   - helpers that tell which operands are treated as signed
package mdu_pkg;

  localparam logic [6:0] MDU_OPCODE = 7'b0110011;
  localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  // rs1 is signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == MDU_MULH) || (f3 == MDU_MULHSU) ||
           (f3 == MDU_DIV)  || (f3 == MDU_REM);
  endfunction

  // rs2 is signed for MULH, DIV and REM.
  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == MDU_MULH) || (f3 == MDU_DIV) || (f3 == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: arithmetic half of the multiply/divide unit.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     load            normal accept: latch magnitudes, sign flags, counter=WIDTH
//     load_special    special-case accept: preload quotient/remainder directly
//     step            one shift-add (MUL*) or restoring-divide (DIV*/REM*) step
//     fix_en          apply sign correction, select the output half, register it
//     funct3          operation select sampled on load/load_special
//     op_a, op_b      rs1/rs2 values sampled on load
//     spec_quot/rem   special-case quotient and remainder
//     cnt_last        iteration counter equals 1 (last step in progress)
//     result          registered result, held until the next fix_en
import mdu_pkg::*;

module mdu_datapath #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             load_special,
  input  logic             step,
  input  logic             fix_en,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] spec_quot,
  input  logic [WIDTH-1:0] spec_rem,
  output logic             cnt_last,
  output logic [WIDTH-1:0] result
);

  logic [2:0]         funct3_q,  funct3_d;
  logic [WIDTH-1:0]   a_mag_q,   a_mag_d;
  logic [WIDTH-1:0]   b_mag_q,   b_mag_d;
  // MUL*: {partial product high, multiplier/product low}.
  // DIV*: low half is the dividend shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  // The partial remainder is always below the divisor, so WIDTH bits hold it;
  // the extra bit only exists in the shifted trial value below.
  logic [WIDTH-1:0]   rem_q,     rem_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               neg_q,     neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   result_q,  result_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, remv, sel;

  always_comb begin
    a_neg = op_a_signed(funct3) & op_a[WIDTH-1];
    b_neg = op_b_signed(funct3) & op_b[WIDTH-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, a_mag_q} : {(WIDTH+1){1'b0}});
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    // When div_ge holds the true difference is below 2^WIDTH, so the
    // modulo-2^WIDTH subtraction is exact.
    rem_sub   = div_shift[WIDTH-1:0] - b_mag_q;

    prod = neg_q     ? -acc_q              : acc_q;
    quot = neg_q     ? -acc_q[WIDTH-1:0]   : acc_q[WIDTH-1:0];
    remv = rem_neg_q ? -rem_q              : rem_q;

    case (funct3_q)
      MDU_MUL:                        sel = prod[WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: sel = prod[2*WIDTH-1:WIDTH];
      MDU_DIV, MDU_DIVU:              sel = quot;
      default:                        sel = remv;
    endcase

    funct3_d  = funct3_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    if (load) begin
      funct3_d  = funct3;
      a_mag_d   = a_mag;
      b_mag_d   = b_mag;
      neg_d     = a_neg ^ b_neg;
      rem_neg_d = a_neg;
      acc_d     = {{WIDTH{1'b0}}, (funct3[2] ? a_mag : b_mag)};
      rem_d     = '0;
      cnt_d     = CNT_W'(WIDTH);
    end else if (load_special) begin
      // Special results are already in final form: no sign fix-up.
      funct3_d  = funct3;
      neg_d     = 1'b0;
      rem_neg_d = 1'b0;
      acc_d     = {{WIDTH{1'b0}}, spec_quot};
      rem_d     = spec_rem;
      cnt_d     = '0;
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (funct3_q[2]) begin
        rem_d = div_ge ? rem_sub : div_shift[WIDTH-1:0];
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
    end

    if (fix_en) begin
      result_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q  <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      funct3_q  <= funct3_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  assign cnt_last = (cnt_q == CNT_W'(1));
  assign result   = result_q;

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: controller of the iterative RV32M multiply/divide unit.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        decoded M instruction present, held until done
//     funct3       operation select (MUL..REMU)
//     op_a, op_b   rs1/rs2 values, only sampled on accept
//     flush        synchronous abort, wins over start
//     stall        start && !done, freezes PC and register-file write
//     busy         high in every state except IDLE
//     done         one-cycle pulse, result valid
//     result       registered result, held until the next operation completes
//     dbg_state    current controller state (mdu_state_t encoding)
//
//   Handshake: start is a level request held by the core; the unit accepts it
//   in IDLE when flush is low, and answers with a single done pulse. The
//   request is not re-sampled in DONE, so a held start is taken again in the
//   following IDLE cycle.
import mdu_pkg::*;

module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t state_q, state_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  logic             accept, special, load, load_special, step, fix_en;
  logic             div_zero, div_ovf, cnt_last;
  logic [WIDTH-1:0] spec_quot, spec_rem;

  always_comb begin
    div_zero = funct3[2] && (op_b == '0);
    // Most negative dividend over -1 overflows; only the signed ops care.
    div_ovf  = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
               (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
    special   = div_zero || div_ovf;
    spec_quot = div_zero ? '1   : op_a;
    spec_rem  = div_zero ? op_a : '0;

    accept       = (state_q == S_IDLE) && start && !flush;
    load         = accept && !special;
    load_special = accept && special;
    step         = (state_q == S_RUN) && !flush;
    fix_en       = (state_q == S_FIX) && !flush;

    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = special ? S_FIX : S_RUN;
        S_RUN:  if (cnt_last) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mdu_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .load_special (load_special),
    .step         (step),
    .fix_en       (fix_en),
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .spec_quot    (spec_quot),
    .spec_rem     (spec_rem),
    .cnt_last     (cnt_last),
    .result       (result)
  );

  assign stall     = start && !done_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
